// File: rtl/arbiter_req_frontend.sv
// Request front end for a 4-way round-robin arbiter: per-port FIFOs,
// grant-driven capture onto a valid/ready bus and a one-cycle ack back.
module arbiter_req_frontend #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      push,
    input  logic [4*DW-1:0] push_data,
    output logic [3:0]      full,
    output logic [3:0]      req,
    input  logic [3:0]      grant,
    output logic            ack,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_id,
    input  logic            out_ready,
    output logic [3:0]      ovf,
    output logic            grant_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]    r_state;
    logic          r_ack;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [1:0]    r_id;
    logic [3:0]    r_ovf;
    logic          r_gerr;

    logic [3:0]    w_nempty;
    logic [3:0]    w_drop;
    logic [DW-1:0] w_head [4];
    logic          w_idle;
    logic          w_onehot;
    logic          w_hit;
    logic          w_cap;
    logic          w_bad;
    logic [1:0]    w_gidx;

    assign w_idle   = (r_state == S_IDLE);
    assign w_onehot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
    assign w_hit    = |(grant & w_nempty);
    assign w_cap    = w_idle && w_onehot && w_hit;
    assign w_bad    = w_idle && (grant != 4'd0) && !(w_onehot && w_hit);
    // Plain OR encode: only meaningful when grant is one-hot.
    assign w_gidx   = {grant[3] | grant[2], grant[3] | grant[1]};

    for (genvar p = 0; p < 4; p++) begin : g_fifo
        logic [DW-1:0] r_mem [DEPTH];
        logic [AW-1:0] r_wptr;
        logic [AW-1:0] r_rptr;
        logic [CW-1:0] r_cnt;
        logic          w_full;
        logic          w_pop;
        logic          w_wr;

        assign w_full = (r_cnt == CW'(DEPTH));
        assign w_pop  = w_cap && (w_gidx == 2'(p));
        // A pop in the same cycle frees the slot a full FIFO needs.
        assign w_wr   = push[p] && (!w_full || w_pop);

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wptr] <= push_data[p*DW +: DW];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                unique case ({w_wr, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign full[p]     = w_full;
        assign w_nempty[p] = (r_cnt != '0);
        assign w_head[p]   = r_mem[r_rptr];
        assign w_drop[p]   = push[p] && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ovf   <= '0;
            r_gerr  <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_drop;
            unique case (r_state)
                S_IDLE: begin
                    if (w_cap) begin
                        r_data  <= w_head[w_gidx];
                        r_id    <= w_gidx;
                        r_valid <= 1'b1;
                        r_state <= S_XFER;
                    end else if (w_bad) begin
                        r_gerr <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Masking outside IDLE keeps the arbiter quiet during a transfer.
    assign req       = w_idle ? w_nempty : 4'd0;
    assign ack       = r_ack;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign ovf       = r_ovf;
    assign grant_err = r_gerr;

endmodule

// File: tb/tb_arbiter_req_frontend.sv
// Directed bench for arbiter_req_frontend with a small round-robin
// arbiter model driving grant from req.
module tb_arbiter_req_frontend;

    logic        clk;
    logic        rst;
    logic [3:0]  push;
    logic [31:0] push_data;
    logic [3:0]  full;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic [3:0]  ovf;
    logic        grant_err;

    logic        rr_mode;
    logic [3:0]  man_grant;
    logic [3:0]  rr_grant;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_idx;

    int checks;
    int failures;
    int ack_cnt;
    logic [7:0] q_d [$];
    logic [1:0] q_id [$];

    arbiter_req_frontend #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .req       (req),
        .grant     (grant),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .ovf       (ovf),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rr_grant = 4'd0;
        rr_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            rr_idx = rr_ptr + 2'(k);
            if (rr_grant == 4'd0 && req[rr_idx]) begin
                rr_grant[rr_idx] = 1'b1;
            end
        end
    end

    assign grant = rr_mode ? rr_grant : man_grant;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 2'd0;
        end else if (ack) begin
            rr_ptr <= out_id + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic drain(input int n);
        q_d.delete();
        q_id.delete();
        ack_cnt = 0;
        for (int c = 0; c < n; c++) begin
            step();
            if (out_valid) begin
                q_d.push_back(out_data);
                q_id.push_back(out_id);
            end
            if (ack) begin
                ack_cnt++;
            end
        end
    endtask

    initial begin
        logic [7:0] exp_d [8];
        logic [1:0] exp_id [8];
        checks    = 0;
        failures  = 0;
        ack_cnt   = 0;
        rst       = 1'b0;
        push      = 4'd0;
        push_data = 32'd0;
        out_ready = 1'b0;
        rr_mode   = 1'b0;
        man_grant = 4'd0;

        // reset state
        #3;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_flags", {ovf, 3'b0, grant_err}, 32'h0);
        step();
        rst = 1'b1;
        step();

        // test 1: async reset mid-transfer
        push = 4'b0010;
        push_data[15:8] = 8'h11;
        step();
        push_data[15:8] = 8'h12;
        step();
        push = 4'd0;
        chk("t1_req", 32'(req), 32'h2);
        man_grant = 4'b0010;
        step();
        man_grant = 4'd0;
        chk("t1_valid_pre", 32'(out_valid), 32'h1);
        chk("t1_data_pre", 32'(out_data), 32'h11);
        #2 rst = 1'b0;
        #1;
        chk("t1_valid_rst", 32'(out_valid), 32'h0);
        chk("t1_req_rst", 32'(req), 32'h0);
        chk("t1_ack_rst", 32'(ack), 32'h0);
        chk("t1_full_rst", 32'(full), 32'h0);
        step();
        rst = 1'b1;
        step();
        step();
        chk("t1_req_post", 32'(req), 32'h0);

        // test 2: single transfer with back-pressure
        do_reset();
        rr_mode = 1'b1;
        push = 4'b0100;
        push_data[23:16] = 8'hA5;
        step();
        push = 4'd0;
        chk("t2_req", 32'(req), 32'h4);
        step();
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_data", 32'(out_data), 32'hA5);
        chk("t2_id", 32'(out_id), 32'h2);
        chk("t2_req_mask", 32'(req), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t2_hold", {out_valid, ack, 14'd0, out_id, out_data},
                {1'b1, 1'b0, 14'd0, 2'd2, 8'hA5});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_ack", 32'(ack), 32'h1);
        chk("t2_valid_lo", 32'(out_valid), 32'h0);
        step();
        chk("t2_ack_lo", 32'(ack), 32'h0);
        chk("t2_req_end", 32'(req), 32'h0);

        // test 3: fill and overflow port 0
        do_reset();
        rr_mode = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push = 4'b0001;
            push_data[7:0] = 8'(i);
            step();
            if (i == 3) chk("t3_full3", 32'(full), 32'h0);
            if (i == 4) chk("t3_full4", 32'(full), 32'h1);
            if (i == 4) chk("t3_ovf4", 32'(ovf), 32'h0);
        end
        push = 4'd0;
        chk("t3_ovf5", 32'(ovf), 32'h1);
        chk("t3_full5", 32'(full), 32'h1);
        rr_mode = 1'b1;
        out_ready = 1'b1;
        drain(20);
        out_ready = 1'b0;
        chk("t3_cnt", 32'(q_d.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_d.size()) chk("t3_order", 32'(q_d[i]), 32'(i + 1));
        end
        chk("t3_req_end", 32'(req), 32'h0);

        // test 4: push while full with simultaneous pop
        do_reset();
        rr_mode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push = 4'b1000;
            push_data[31:24] = 8'h30 + 8'(i);
            step();
        end
        chk("t4_full", 32'(full), 32'h8);
        man_grant = 4'b1000;
        push_data[31:24] = 8'h77;
        step();
        push = 4'd0;
        man_grant = 4'd0;
        chk("t4_cap", 32'(out_data), 32'h31);
        chk("t4_full_kept", 32'(full), 32'h8);
        chk("t4_ovf", 32'(ovf), 32'h0);
        rr_mode = 1'b1;
        out_ready = 1'b1;
        drain(20);
        out_ready = 1'b0;
        chk("t4_cnt", 32'(q_d.size()), 32'd4);
        if (q_d.size() == 4) begin
            chk("t4_d0", 32'(q_d[0]), 32'h32);
            chk("t4_d3", 32'(q_d[3]), 32'h77);
        end

        // test 5: round-robin across all ports
        do_reset();
        rr_mode = 1'b0;
        push = 4'b1111;
        push_data = 32'h31211101;
        step();
        push_data = 32'h32221202;
        step();
        push = 4'd0;
        chk("t5_req", 32'(req), 32'hF);
        for (int i = 0; i < 8; i++) begin
            exp_id[i] = 2'(i % 4);
            exp_d[i]  = 8'h10 * 8'(i % 4) + 8'(i / 4 + 1);
        end
        rr_mode = 1'b1;
        out_ready = 1'b1;
        drain(30);
        out_ready = 1'b0;
        chk("t5_cnt", 32'(q_d.size()), 32'd8);
        chk("t5_acks", 32'(ack_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_id.size()) begin
                chk("t5_id", 32'(q_id[i]), 32'(exp_id[i]));
                chk("t5_data", 32'(q_d[i]), 32'(exp_d[i]));
            end
        end

        // test 6: illegal grants
        do_reset();
        rr_mode = 1'b0;
        push = 4'b0011;
        push_data = 32'h00000A0B;
        step();
        push = 4'd0;
        chk("t6_gerr0", 32'(grant_err), 32'h0);
        man_grant = 4'b0011;
        step();
        chk("t6_gerr_multi", 32'(grant_err), 32'h1);
        chk("t6_valid_multi", 32'(out_valid), 32'h0);
        chk("t6_req_multi", 32'(req), 32'h3);
        man_grant = 4'b0100;
        step();
        chk("t6_gerr_noreq", 32'(grant_err), 32'h1);
        chk("t6_valid_noreq", 32'(out_valid), 32'h0);
        chk("t6_req_noreq", 32'(req), 32'h3);
        man_grant = 4'd0;
        step();
        chk("t6_gerr_sticky", 32'(grant_err), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
